// File: rtl/atm_session_ctrl_pkg.sv
// Shared types for the ATM session controller: FSM states, error codes and
// the status encodings that the combinational authenticator reports.
package atm_session_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StLookup  = 3'd1,
        StWaitPin = 3'd2,
        StCheck   = 3'd3,
        StSession = 3'd4,
        StBusy    = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        ErrNone     = 3'd0,
        ErrNotFound = 3'd1,
        ErrLocked   = 3'd2,
        ErrBadPin   = 3'd3,
        ErrLockout  = 3'd4,
        ErrTimeout  = 3'd5
    } err_code_e;

    localparam logic ACCOUNT_FOUND         = 1'b1;
    localparam logic ACCOUNT_AUTHENTICATED = 1'b1;

    localparam int unsigned AccNumW = 4;
    localparam int unsigned PinW    = 16;

endpackage

// File: rtl/atm_session_ctrl_if.sv
// Signal bundle between the ATM front end / authenticator / datapath and the
// session controller. The controller uses the slave view.
interface atm_session_ctrl_if #(
    parameter int unsigned NUM_ACCOUNTS = 10
);
    import atm_session_ctrl_pkg::*;

    logic                    card_in;
    logic [AccNumW-1:0]      acc_num;
    logic                    pin_valid;
    logic [PinW-1:0]         pin;
    logic                    logout;
    logic                    op_req;
    logic                    op_done;
    logic                    auth_found;
    logic                    auth_ok;
    logic [AccNumW-1:0]      auth_index;
    logic [AccNumW-1:0]      auth_acc_num;
    logic [PinW-1:0]         auth_pin;
    logic                    session_active;
    logic [AccNumW-1:0]      session_index;
    logic                    op_grant;
    logic                    err;
    logic [2:0]              err_code;
    logic [NUM_ACCOUNTS-1:0] locked_mask;

    modport master (
        output card_in, acc_num, pin_valid, pin, logout, op_req, op_done,
        output auth_found, auth_ok, auth_index,
        input  auth_acc_num, auth_pin, session_active, session_index, op_grant,
        input  err, err_code, locked_mask
    );

    modport slave (
        input  card_in, acc_num, pin_valid, pin, logout, op_req, op_done,
        input  auth_found, auth_ok, auth_index,
        output auth_acc_num, auth_pin, session_active, session_index, op_grant,
        output err, err_code, locked_mask
    );

endinterface

// File: rtl/atm_session_ctrl_session_timer.sv
// Idle timer for WAIT_PIN/SESSION: saturating up-counter whose expiry flag is
// raised during the cycle the count reads TIMEOUT_CYCLES-1.
module atm_session_ctrl_session_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != CntW'(TIMEOUT_CYCLES))) begin
            count_d = count_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && (count_q == CntW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/atm_session_ctrl.sv
// ATM session sequencer: card lookup, PIN checking with lockout, idle timeouts
// and single-transaction grant to the downstream datapath.
module atm_session_ctrl
    import atm_session_ctrl_pkg::*;
#(
    parameter int unsigned MAX_ATTEMPTS   = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned NUM_ACCOUNTS   = 10
) (
    input logic               clk,
    input logic               rst,
    atm_session_ctrl_if.slave bus
);
    localparam int unsigned AttW = $clog2(MAX_ATTEMPTS + 1);

    state_e                  state_q, state_d;
    logic [AttW-1:0]         attempts_q, attempts_d, attempts_inc;
    logic [AccNumW-1:0]      auth_acc_num_q, auth_acc_num_d;
    logic [PinW-1:0]         auth_pin_q, auth_pin_d;
    logic [AccNumW-1:0]      session_index_q, session_index_d;
    logic                    err_q, err_d;
    err_code_e               err_code_q, err_code_d;
    logic [NUM_ACCOUNTS-1:0] locked_mask_q, locked_mask_d;
    logic                    session_active_q, op_grant_q;
    logic                    timer_clear, timer_enable, timer_expired;
    logic                    index_locked;

    assign timer_enable = (state_q == StWaitPin) || (state_q == StSession);
    assign timer_clear  = (state_q == StIdle) || (state_q == StLookup) || (state_q == StCheck) ||
                          ((state_q == StBusy) && bus.op_done);
    assign attempts_inc = attempts_q + AttW'(1);

    atm_session_ctrl_session_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_session_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expired(timer_expired)
    );

    // Indices beyond the lock mask are never considered locked.
    always_comb begin
        index_locked = 1'b0;
        for (int unsigned i = 0; i < NUM_ACCOUNTS; i++) begin
            if (bus.auth_index == AccNumW'(i) && locked_mask_q[i]) index_locked = 1'b1;
        end
    end

    always_comb begin
        state_d         = state_q;
        attempts_d      = attempts_q;
        auth_acc_num_d  = auth_acc_num_q;
        auth_pin_d      = auth_pin_q;
        session_index_d = session_index_q;
        err_d           = 1'b0;
        err_code_d      = err_code_q;
        locked_mask_d   = locked_mask_q;

        unique case (state_q)
            StIdle: begin
                if (bus.card_in) begin
                    auth_acc_num_d = bus.acc_num;
                    state_d        = StLookup;
                end
            end
            StLookup: begin
                if (bus.auth_found != ACCOUNT_FOUND) begin
                    err_d      = 1'b1;
                    err_code_d = ErrNotFound;
                    state_d    = StIdle;
                end else if (index_locked) begin
                    err_d      = 1'b1;
                    err_code_d = ErrLocked;
                    state_d    = StIdle;
                end else begin
                    session_index_d = bus.auth_index;
                    attempts_d      = '0;
                    state_d         = StWaitPin;
                end
            end
            StWaitPin: begin
                if (bus.pin_valid) begin
                    auth_pin_d = bus.pin;
                    state_d    = StCheck;
                end else if (bus.logout) begin
                    state_d = StIdle;
                end else if (timer_expired) begin
                    err_d      = 1'b1;
                    err_code_d = ErrTimeout;
                    state_d    = StIdle;
                end
            end
            StCheck: begin
                if (bus.auth_ok == ACCOUNT_AUTHENTICATED) begin
                    state_d = StSession;
                end else if (attempts_inc == AttW'(MAX_ATTEMPTS)) begin
                    for (int unsigned i = 0; i < NUM_ACCOUNTS; i++) begin
                        if (session_index_q == AccNumW'(i)) locked_mask_d[i] = 1'b1;
                    end
                    err_d      = 1'b1;
                    err_code_d = ErrLockout;
                    state_d    = StIdle;
                end else begin
                    attempts_d = attempts_inc;
                    err_d      = 1'b1;
                    err_code_d = ErrBadPin;
                    state_d    = StWaitPin;
                end
            end
            StSession: begin
                if (bus.logout) begin
                    state_d = StIdle;
                end else if (bus.op_req) begin
                    state_d = StBusy;
                end else if (timer_expired) begin
                    err_d      = 1'b1;
                    err_code_d = ErrTimeout;
                    state_d    = StIdle;
                end
            end
            StBusy: begin
                if (bus.op_done) state_d = StSession;
            end
            default: state_d = StIdle;
        endcase

        if ((state_d == StIdle) && (state_q != StIdle)) begin
            auth_pin_d = '0;
            attempts_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= StIdle;
            attempts_q       <= '0;
            auth_acc_num_q   <= '0;
            auth_pin_q       <= '0;
            session_index_q  <= '0;
            err_q            <= 1'b0;
            err_code_q       <= ErrNone;
            locked_mask_q    <= '0;
            session_active_q <= 1'b0;
            op_grant_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            attempts_q       <= attempts_d;
            auth_acc_num_q   <= auth_acc_num_d;
            auth_pin_q       <= auth_pin_d;
            session_index_q  <= session_index_d;
            err_q            <= err_d;
            err_code_q       <= err_code_d;
            locked_mask_q    <= locked_mask_d;
            session_active_q <= (state_d == StSession) || (state_d == StBusy);
            op_grant_q       <= (state_d == StBusy);
        end
    end

    assign bus.auth_acc_num   = auth_acc_num_q;
    assign bus.auth_pin       = auth_pin_q;
    assign bus.session_active = session_active_q;
    assign bus.session_index  = session_index_q;
    assign bus.op_grant       = op_grant_q;
    assign bus.err            = err_q;
    assign bus.err_code       = err_code_q;
    assign bus.locked_mask    = locked_mask_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Bench for atm_session_ctrl: directed scenarios plus randomized sessions
// scored against a transaction-level model of accounts, PINs and locks.
module tb_atm_session_ctrl;
    localparam int unsigned MaxAtt = 3;
    localparam int unsigned Tmo    = 8;
    localparam int unsigned NA     = 10;

    logic          clk = 1'b0;
    logic          rst;
    int            vectors     = 0;
    int            miscompares = 0;
    logic [NA-1:0] model_mask  = '0;

    atm_session_ctrl_if #(.NUM_ACCOUNTS(NA)) bus ();

    atm_session_ctrl #(
        .MAX_ATTEMPTS  (MaxAtt),
        .TIMEOUT_CYCLES(Tmo),
        .NUM_ACCOUNTS  (NA)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Account database: numbers 1..10 live at index n-1, PIN = 1234 + 1111*index.
    function automatic logic [15:0] good_pin(input int idx);
        return 16'(1234 + 1111 * idx);
    endfunction

    always_comb begin
        bus.auth_found = (bus.auth_acc_num >= 4'd1) && (bus.auth_acc_num <= 4'd10);
        bus.auth_index = bus.auth_found ? (bus.auth_acc_num - 4'd1) : 4'd0;
        bus.auth_ok    = bus.auth_found && (bus.auth_pin == good_pin(int'(bus.auth_acc_num) - 1));
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic insert_card(input logic [3:0] acc);
        bus.acc_num = acc;
        bus.card_in = 1'b1;
        step();
        bus.card_in = 1'b0;
        step();
    endtask

    task automatic enter_pin(input logic [15:0] p);
        bus.pin       = p;
        bus.pin_valid = 1'b1;
        step();
        bus.pin_valid = 1'b0;
        step();
    endtask

    task automatic do_logout();
        bus.logout = 1'b1;
        step();
        bus.logout = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        vectors++;
        if ({bus.auth_acc_num, bus.auth_pin, bus.session_active, bus.session_index,
             bus.op_grant, bus.err, bus.err_code, bus.locked_mask} !== 40'd0) begin
            miscompares++;
            $display("FAIL reset_values: got acc=%0d pin=%0d act=%0b idx=%0d grant=%0b err=%0b code=%0d mask=%b, want all 0",
                     bus.auth_acc_num, bus.auth_pin, bus.session_active, bus.session_index,
                     bus.op_grant, bus.err, bus.err_code, bus.locked_mask);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_card_path();
        insert_card(4'd3);
        vectors++;
        if ({bus.err, bus.session_active, bus.auth_acc_num} !== {1'b0, 1'b0, 4'd3}) begin
            miscompares++;
            $display("FAIL card_latch: got err=%0b act=%0b acc=%0d, want err=0 act=0 acc=3",
                     bus.err, bus.session_active, bus.auth_acc_num);
        end
        bus.pin       = 16'd3456;
        bus.pin_valid = 1'b1;
        step();
        bus.pin_valid = 1'b0;
        vectors++;
        if (bus.session_active !== 1'b0) begin
            miscompares++;
            $display("FAIL pin_early: got act=%0b one edge after pin, want 0", bus.session_active);
        end
        step();
        vectors++;
        if ({bus.session_active, bus.session_index, bus.err} !== {1'b1, 4'd2, 1'b0}) begin
            miscompares++;
            $display("FAIL pin_ok: got act=%0b idx=%0d err=%0b, want act=1 idx=2 err=0",
                     bus.session_active, bus.session_index, bus.err);
        end
        do_logout();
        vectors++;
        if ({bus.session_active, bus.auth_pin} !== {1'b0, 16'd0}) begin
            miscompares++;
            $display("FAIL logout_clear: got act=%0b pin=%0d, want act=0 pin=0",
                     bus.session_active, bus.auth_pin);
        end
    endtask

    task automatic test_not_found();
        insert_card(4'd12);
        vectors++;
        if ({bus.err, bus.err_code} !== {1'b1, 3'd1}) begin
            miscompares++;
            $display("FAIL not_found: got err=%0b code=%0d, want err=1 code=1", bus.err, bus.err_code);
        end
        step();
        vectors++;
        if ({bus.err, bus.err_code, bus.session_active} !== {1'b0, 3'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL err_strobe: got err=%0b code=%0d act=%0b, want err=0 code=1 act=0",
                     bus.err, bus.err_code, bus.session_active);
        end
    endtask

    task automatic test_lockout();
        logic [2:0] want [3] = '{3'd3, 3'd3, 3'd4};
        insert_card(4'd5);
        for (int i = 0; i < 3; i++) begin
            enter_pin(16'd1111);
            vectors++;
            if ({bus.err, bus.err_code} !== {1'b1, want[i]}) begin
                miscompares++;
                $display("FAIL lockout_try%0d: got err=%0b code=%0d, want err=1 code=%0d",
                         i, bus.err, bus.err_code, want[i]);
            end
        end
        model_mask[4] = 1'b1;
        vectors++;
        if (bus.locked_mask !== model_mask) begin
            miscompares++;
            $display("FAIL lock_mask: got %b, want %b", bus.locked_mask, model_mask);
        end
        step();
        insert_card(4'd5);
        vectors++;
        if ({bus.err, bus.err_code} !== {1'b1, 3'd2}) begin
            miscompares++;
            $display("FAIL locked_reinsert: got err=%0b code=%0d, want err=1 code=2", bus.err, bus.err_code);
        end
        step();
    endtask

    task automatic test_wait_pin_timeout();
        insert_card(4'd3);
        repeat (Tmo - 1) step();
        vectors++;
        if (bus.err !== 1'b0) begin
            miscompares++;
            $display("FAIL wait_pin_early_timeout: got err=%0b, want 0", bus.err);
        end
        step();
        vectors++;
        if ({bus.err, bus.err_code, bus.session_active} !== {1'b1, 3'd5, 1'b0}) begin
            miscompares++;
            $display("FAIL wait_pin_timeout: got err=%0b code=%0d act=%0b, want err=1 code=5 act=0",
                     bus.err, bus.err_code, bus.session_active);
        end
        step();
    endtask

    task automatic test_pin_over_logout();
        insert_card(4'd7);
        bus.pin    = good_pin(6);
        bus.pin_valid = 1'b1;
        bus.logout = 1'b1;
        step();
        bus.pin_valid = 1'b0;
        bus.logout = 1'b0;
        step();
        vectors++;
        if ({bus.session_active, bus.session_index} !== {1'b1, 4'd6}) begin
            miscompares++;
            $display("FAIL pin_over_logout: got act=%0b idx=%0d, want act=1 idx=6",
                     bus.session_active, bus.session_index);
        end
        do_logout();
    endtask

    task automatic test_busy_hold();
        bit bad = 1'b0;
        insert_card(4'd3);
        enter_pin(16'd3456);
        bus.op_req = 1'b1;
        step();
        bus.op_req = 1'b0;
        vectors++;
        if (bus.op_grant !== 1'b1) begin
            miscompares++;
            $display("FAIL op_grant_rise: got %0b, want 1", bus.op_grant);
        end
        repeat (20) begin
            step();
            if (bus.err || !bus.op_grant || !bus.session_active) bad = 1'b1;
        end
        vectors++;
        if (bad !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_hold: got disturbance=%0b over 20 cycles, want 0", bad);
        end
        bus.op_done = 1'b1;
        step();
        bus.op_done = 1'b0;
        vectors++;
        if ({bus.op_grant, bus.session_active} !== {1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL op_done: got grant=%0b act=%0b, want grant=0 act=1", bus.op_grant, bus.session_active);
        end
        repeat (Tmo - 1) step();
        vectors++;
        if ({bus.err, bus.session_active} !== {1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL session_early_timeout: got err=%0b act=%0b, want err=0 act=1",
                     bus.err, bus.session_active);
        end
        step();
        vectors++;
        if ({bus.err, bus.err_code, bus.session_active} !== {1'b1, 3'd5, 1'b0}) begin
            miscompares++;
            $display("FAIL session_timeout: got err=%0b code=%0d act=%0b, want err=1 code=5 act=0",
                     bus.err, bus.err_code, bus.session_active);
        end
        step();
    endtask

    task automatic test_logout_op_req();
        insert_card(4'd3);
        enter_pin(16'd3456);
        bus.logout = 1'b1;
        bus.op_req = 1'b1;
        step();
        bus.logout = 1'b0;
        bus.op_req = 1'b0;
        vectors++;
        if ({bus.session_active, bus.op_grant} !== 2'b00) begin
            miscompares++;
            $display("FAIL logout_vs_op: got act=%0b grant=%0b, want 0 0", bus.session_active, bus.op_grant);
        end
        step();
        vectors++;
        if (bus.op_grant !== 1'b0) begin
            miscompares++;
            $display("FAIL logout_vs_op_late: got grant=%0b, want 0", bus.op_grant);
        end
    endtask

    task automatic test_rst_in_busy();
        insert_card(4'd3);
        enter_pin(16'd3456);
        bus.op_req = 1'b1;
        step();
        bus.op_req = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_mask = '0;
        vectors++;
        if ({bus.auth_acc_num, bus.auth_pin, bus.session_active, bus.session_index,
             bus.op_grant, bus.err, bus.err_code, bus.locked_mask} !== 40'd0) begin
            miscompares++;
            $display("FAIL rst_in_busy: got acc=%0d pin=%0d act=%0b idx=%0d grant=%0b err=%0b code=%0d mask=%b, want all 0",
                     bus.auth_acc_num, bus.auth_pin, bus.session_active, bus.session_index,
                     bus.op_grant, bus.err, bus.err_code, bus.locked_mask);
        end
        step();
    endtask

    task automatic test_random_sessions(input int n);
        for (int s = 0; s < n; s++) begin
            logic [3:0] acc;
            int         idx;
            int         tries;
            bit         done;
            acc   = 4'($urandom_range(0, 15));
            idx   = int'(acc) - 1;
            tries = 0;
            done  = 1'b0;
            insert_card(acc);
            vectors++;
            if (acc < 4'd1 || acc > 4'd10) begin
                if ({bus.err, bus.err_code} !== {1'b1, 3'd1}) begin
                    miscompares++;
                    $display("FAIL rnd_not_found acc=%0d: got err=%0b code=%0d, want 1 1", acc, bus.err, bus.err_code);
                end
            end else if (model_mask[idx]) begin
                if ({bus.err, bus.err_code} !== {1'b1, 3'd2}) begin
                    miscompares++;
                    $display("FAIL rnd_locked acc=%0d: got err=%0b code=%0d, want 1 2", acc, bus.err, bus.err_code);
                end
            end else begin
                if ({bus.err, bus.session_active} !== 2'b00) begin
                    miscompares++;
                    $display("FAIL rnd_lookup acc=%0d: got err=%0b act=%0b, want 0 0", acc, bus.err, bus.session_active);
                end
                while (!done) begin
                    bit          good;
                    logic [15:0] p;
                    good = 1'($urandom_range(0, 1));
                    p    = good ? good_pin(idx) : good_pin(idx) + 16'($urandom_range(1, 500));
                    enter_pin(p);
                    vectors++;
                    if (good) begin
                        done = 1'b1;
                        if ({bus.session_active, bus.session_index, bus.err} !== {1'b1, 4'(idx), 1'b0}) begin
                            miscompares++;
                            $display("FAIL rnd_login acc=%0d: got act=%0b idx=%0d err=%0b, want 1 %0d 0",
                                     acc, bus.session_active, bus.session_index, bus.err, idx);
                        end
                        if ($urandom_range(0, 1) == 1) begin
                            bus.op_req = 1'b1;
                            step();
                            bus.op_req = 1'b0;
                            repeat ($urandom_range(0, 4)) step();
                            bus.op_done = 1'b1;
                            step();
                            bus.op_done = 1'b0;
                            vectors++;
                            if ({bus.op_grant, bus.session_active} !== 2'b01) begin
                                miscompares++;
                                $display("FAIL rnd_op acc=%0d: got grant=%0b act=%0b, want 0 1",
                                         acc, bus.op_grant, bus.session_active);
                            end
                        end
                        do_logout();
                    end else begin
                        tries++;
                        if (tries == MaxAtt) begin
                            done            = 1'b1;
                            model_mask[idx] = 1'b1;
                            if ({bus.err, bus.err_code, bus.locked_mask} !== {1'b1, 3'd4, model_mask}) begin
                                miscompares++;
                                $display("FAIL rnd_lockout acc=%0d: got err=%0b code=%0d mask=%b, want 1 4 %b",
                                         acc, bus.err, bus.err_code, bus.locked_mask, model_mask);
                            end
                        end else if ({bus.err, bus.err_code, bus.session_active} !== {1'b1, 3'd3, 1'b0}) begin
                            miscompares++;
                            $display("FAIL rnd_bad_pin acc=%0d: got err=%0b code=%0d act=%0b, want 1 3 0",
                                     acc, bus.err, bus.err_code, bus.session_active);
                        end
                    end
                end
            end
            step();
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.card_in   = 1'b0;
        bus.acc_num   = 4'd0;
        bus.pin_valid = 1'b0;
        bus.pin       = 16'd0;
        bus.logout    = 1'b0;
        bus.op_req    = 1'b0;
        bus.op_done   = 1'b0;
        test_reset();
        test_card_path();
        test_not_found();
        test_lockout();
        test_wait_pin_timeout();
        test_pin_over_logout();
        test_busy_hold();
        test_logout_op_req();
        test_rst_in_busy();
        test_random_sessions(40);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
